// File: rtl/booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_mult
// Description : Sequential radix-2 Booth multiplier producing a signed 2N-bit
//               product one multiplier bit per clock; a reset pulse starts it.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_mult #(
    parameter int NB = 2,
    parameter int N  = 2 ** NB
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   im,
    input  logic [N-1:0]   iq,
    output logic           pd,
    output logic [2*N-1:0] p
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [NB-1:0] c_last = NB'(N - 1);

    state_t         r_state;
    state_t         w_next;
    logic [N:0]     r_a;
    logic [N:0]     r_m;
    logic [N-1:0]   r_q;
    logic           r_qm1;
    logic [NB-1:0]  r_cnt;
    logic           r_pd;
    logic [2*N-1:0] r_p;

    logic [N:0]     w_sum;
    logic [N:0]     w_a_sh;
    logic [N-1:0]   w_q_sh;
    logic           w_last;

    assign w_last = (r_cnt == c_last);

    // A and M carry one guard bit so that negating the most negative
    // multiplicand stays representable.
    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_sh = {w_sum[N], w_sum[N:1]};
    assign w_q_sh = {w_sum[0], r_q[N-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = DONE;
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_m   <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_pd  <= 1'b0;
            r_p   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_m   <= {im[N-1], im};
                    r_q   <= iq;
                    r_a   <= '0;
                    r_qm1 <= 1'b0;
                    r_cnt <= '0;
                end
                RUN: begin
                    r_a   <= w_a_sh;
                    r_q   <= w_q_sh;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + NB'(1);
                    if (w_last) begin
                        r_p  <= {w_a_sh[N-1:0], w_q_sh};
                        r_pd <= 1'b1;
                    end
                end
                default: begin
                    r_pd <= r_pd;
                end
            endcase
        end
    end

    assign pd = r_pd;
    assign p  = r_p;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_mult
// Description : Scoreboard bench for booth_seq_mult (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_mult;

    localparam int c_nb = 2;
    localparam int c_n  = 4;

    logic           clk;
    logic           rst;
    logic [c_n-1:0] im;
    logic [c_n-1:0] iq;
    logic           pd;
    logic [7:0]     p;

    int n_vec;
    int n_err;
    logic [7:0] exp_q[$];

    booth_seq_mult #(.NB(c_nb), .N(c_n)) u_dut (
        .clk (clk),
        .rst (rst),
        .im  (im),
        .iq  (iq),
        .pd  (pd),
        .p   (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic signed [3:0] a, input logic signed [3:0] b);
        int prod;
        prod = int'(a) * int'(b);
        return prod[7:0];
    endfunction

    // Called at a negedge with rst just released; expects pd on the 5th edge.
    task automatic wait_done(input string tag);
        int edges;
        logic [7:0] e;
        edges = 0;
        while (!pd && edges < 10) begin
            @(negedge clk);
            edges++;
            if (edges < 5) check({tag, "_pd_early"}, {15'd0, pd}, 16'd0);
        end
        check({tag, "_lat"}, 16'(edges), 16'd5);
        check({tag, "_pd"}, {15'd0, pd}, 16'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_p"}, {8'd0, p}, {8'd0, e});
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rst = 1'b0;
        im  = a;
        iq  = b;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        rst = 1'b1;
        wait_done(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        im    = '0;
        iq    = '0;

        // reset held across several edges
        repeat (3) @(negedge clk);
        check("rst_pd", {15'd0, pd}, 16'd0);
        check("rst_p", {8'd0, p}, 16'd0);

        // corners
        run_op("m8xm8", 4'h8, 4'h8);
        check("m8xm8_val", {8'd0, p}, 16'h0040);
        run_op("m8x7", 4'h8, 4'h7);
        check("m8x7_val", {8'd0, p}, 16'h00C8);
        run_op("7x7", 4'h7, 4'h7);
        check("7x7_val", {8'd0, p}, 16'h0031);
        run_op("0xm8", 4'h0, 4'h8);
        check("0xm8_val", {8'd0, p}, 16'h0000);

        // hold after done
        run_op("hold", 4'd3, 4'hE);
        im = 4'h7;
        iq = 4'h5;
        repeat (4) @(negedge clk);
        check("hold_p", {8'd0, p}, 16'h00FA);
        check("hold_pd", {15'd0, pd}, 16'd1);

        // abort mid-operation
        @(negedge clk);
        rst = 1'b0;
        im  = 4'd5;
        iq  = 4'd5;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_pd", {15'd0, pd}, 16'd0);
        check("abort_p", {8'd0, p}, 16'd0);
        im = 4'hD;
        iq = 4'd6;
        exp_q.push_back(model(4'hD, 4'd6));
        @(negedge clk);
        rst = 1'b1;
        wait_done("abort");
        check("abort_val", {8'd0, p}, 16'h00EE);

        // exhaustive sweep
        for (int i = 0; i < 256; i++) begin
            run_op("sweep", i[7:4], i[3:0]);
        end

        // random pairs
        for (int k = 0; k < 20; k++) begin
            run_op("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        check("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
